// File: rtl/memory_data_register_param.sv
// ---------------------------------------------------------------------------
// memory_data_register_param
//
// Memory data register (MDR) for the Mini-SRC datapath. It holds one
// WIDTH-bit word. The word is loaded either directly from the internal bus
// or from memory through a request/ready handshake. A memory read can
// extract a byte, a halfword or a full word, with sign or zero extension.
// An optional wait-state timeout abandons a read that memory never answers.
//
// Parameters
//   WIDTH    register / memory data width (16, 32 or 64)
//   TIMEOUT  maximum WAIT cycles before a read is abandoned (0 = never)
//   OFF_W    byte-offset width (derived)
//
// Ports
//   in_clk        clock, rising edge
//   in_clr        asynchronous active-low reset
//   in_bus        data from the internal bus
//   in_memory     data from memory, valid while in_mem_ready=1
//   in_write      load from in_bus (IDLE only)
//   in_read_req   start a memory read (IDLE only, wins over in_write)
//   in_mem_ready  memory data valid this cycle
//   in_size       00 byte, 01 halfword, 1x full word
//   in_signed     1 = sign-extend sub-word reads
//   in_addr_lo    byte offset within the memory word
//   out           register contents
//   out_busy      high while a read is outstanding
//   out_done      one-cycle pulse: read completed, out holds the new value
//   out_timeout   one-cycle pulse: read abandoned, out unchanged
// ---------------------------------------------------------------------------
module memory_data_register_param #(
  parameter  int WIDTH   = 32,
  parameter  int TIMEOUT = 16,
  localparam int OFF_W   = $clog2(WIDTH / 8)
) (
  input  logic             in_clk,
  input  logic             in_clr,
  input  logic [WIDTH-1:0] in_bus,
  input  logic [WIDTH-1:0] in_memory,
  input  logic             in_write,
  input  logic             in_read_req,
  input  logic             in_mem_ready,
  input  logic [1:0]       in_size,
  input  logic             in_signed,
  input  logic [OFF_W-1:0] in_addr_lo,
  output logic [WIDTH-1:0] out,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_timeout
);

  // A zero TIMEOUT still needs a one-bit counter so the vector stays legal.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t             state_r,   state_s;
  logic [CNT_W-1:0]   cnt_r,     cnt_s;
  logic [1:0]         size_r,    size_s;
  logic               signed_r,  signed_s;
  logic [OFF_W-1:0]   off_r,     off_s;
  logic [WIDTH-1:0]   data_r,    data_s;
  logic               busy_r,    busy_s;
  logic               done_r,    done_s;
  logic               timeout_r, timeout_s;

  // Select the addressed byte/halfword and extend it to the full width.
  // Halfwords clear the offset LSB, so a misaligned halfword is aligned down.
  function automatic logic [WIDTH-1:0] extract(
    input logic [WIDTH-1:0] mem,
    input logic [1:0]       size,
    input logic             sgn,
    input logic [OFF_W-1:0] off
  );
    logic [OFF_W-1:0] hoff;
    logic [7:0]       b;
    logic [15:0]      h;
    logic [WIDTH-1:0] r;
    hoff    = off;
    hoff[0] = 1'b0;
    b = 8'(mem >> {off, 3'b000});
    h = 16'(mem >> {hoff, 3'b000});
    case (size)
      2'b00:   r = {{(WIDTH - 8){sgn & b[7]}}, b};
      2'b01:   r = {{(WIDTH - 16){sgn & h[15]}}, h};
      default: r = mem;
    endcase
    return r;
  endfunction

  // Next-state, datapath and pulse decode for the IDLE/WAIT handshake.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    size_s    = size_r;
    signed_s  = signed_r;
    off_s     = off_r;
    data_s    = data_r;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_read_req) begin
          state_s  = ST_WAIT;
          size_s   = in_size;
          signed_s = in_signed;
          off_s    = in_addr_lo;
          cnt_s    = {CNT_W{1'b0}};
          busy_s   = 1'b1;
        end else if (in_write) begin
          data_s = in_bus;
        end else begin
          data_s = data_r;
        end
      end
      ST_WAIT: begin
        busy_s = 1'b1;
        if (in_mem_ready) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          data_s  = extract(in_memory, size_r, signed_r, off_r);
        end else if (TIMEOUT_EN && (cnt_r == CNT_LAST)) begin
          state_s   = ST_IDLE;
          busy_s    = 1'b0;
          timeout_s = 1'b1;
        end else if (cnt_r != CNT_MAX) begin
          cnt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any outstanding read silently.
  always_ff @(posedge in_clk or negedge in_clr) begin
    if (!in_clr) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      size_r    <= 2'b00;
      signed_r  <= 1'b0;
      off_r     <= {OFF_W{1'b0}};
      data_r    <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      size_r    <= size_s;
      signed_r  <= signed_s;
      off_r     <= off_s;
      data_r    <= data_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      timeout_r <= timeout_s;
    end
  end

  assign out         = data_r;
  assign out_busy    = busy_r;
  assign out_done    = done_r;
  assign out_timeout = timeout_r;

endmodule

// File: doc/memory_data_register_param.md
# memory_data_register_param

Parametrised memory data register (MDR) for the Mini-SRC datapath with a handshaked memory read path. It holds one WIDTH-bit word that can be loaded directly from the internal bus or from memory. Memory reads use a request/ready handshake with an optional wait-state timeout, and support byte, halfword or full-word extraction with sign or zero extension. It sits between the memory interface and the bus, and is driven by the control unit.

## Interface
- WIDTH, 32, register and memory data width; must be 16, 32 or 64.
- TIMEOUT, 16, maximum number of WAIT cycles before a read is abandoned; 0 disables the timeout.
- OFF_W, $clog2(WIDTH/8), byte-offset width; derived, not overridden.

- in_clk  input  1  clock; all state updates on the rising edge.
- in_clr  input  1  reset, asynchronous, active-low.
- in_bus  input  WIDTH  data from the internal bus.
- in_memory  input  WIDTH  data from memory; valid when in_mem_ready=1.
- in_write  input  1  load the register from in_bus (IDLE only).
- in_read_req  input  1  start a memory read (IDLE only).
- in_mem_ready  input  1  memory data valid this cycle.
- in_size  input  2  read size: 00 byte, 01 halfword, 10/11 full word.
- in_signed  input  1  1 = sign-extend sub-word reads, 0 = zero-extend.
- in_addr_lo  input  OFF_W  byte offset within the memory word.
- out  output  WIDTH  register contents.
- out_busy  output  1  high while a read is outstanding.
- out_done  output  1  one-cycle pulse: a read completed and out holds the new value.
- out_timeout  output  1  one-cycle pulse: a read was abandoned.

## Operation
- States: IDLE, WAIT.
- IDLE:
  - in_read_req=1: latch in_size, in_signed and in_addr_lo; clear the wait counter; go to WAIT. in_write is ignored in the same cycle (read has priority).
  - Otherwise, in_write=1: out <= in_bus.
- WAIT (out_busy=1):
  - in_mem_ready=1: out <= extracted value; out_done=1 next cycle; go to IDLE.
  - Else if TIMEOUT!=0 and the counter reaches TIMEOUT-1: out unchanged; out_timeout=1 next cycle; go to IDLE.
  - Else: counter increments.
  - in_write and in_read_req are ignored in WAIT.
- Extraction uses the latched size, signed flag and offset:
  - Byte: in_memory[8*off +: 8].
  - Halfword: in_memory[16*(off>>1) +: 16]; the offset LSB is ignored, so misaligned halfwords are forced to alignment.
  - Full word: in_memory unchanged; offset and signed flag ignored.
  - Sub-word results are extended to WIDTH using the sign bit (in_signed=1) or zeros.
- Counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.

## Timing
- Reset (in_clr=0, asynchronous): out=0, out_busy=0, out_done=0, out_timeout=0, state IDLE, counter 0.
- Reset during WAIT aborts the read; no done or timeout pulse is produced.
- Direct write: in_write sampled at edge N; out is valid after edge N.
- Read request sampled at edge N: out_busy is high after edge N.
  - in_mem_ready is sampled from edge N+1 onward; a ready coincident with the request edge is ignored.
  - Ready sampled at edge M: out updates and out_done pulses after edge M; out_busy drops after edge M.
  - Minimum read latency is 2 edges (request edge plus ready edge).
- A new in_read_req may be issued in the cycle out_done is high, since the block is back in IDLE.
- Timeout occurs exactly TIMEOUT edges after the request edge with no ready sampled.
- out_done and out_timeout are registered, never high together, and last exactly one cycle.

## Test plan
- Reset then write: assert in_clr=0 → all outputs 0; then in_write=1 with in_bus=32'hDEADBEEF → out=32'hDEADBEEF one edge later, out_done stays 0.
- Full-word read with 3 wait states: request, then in_mem_ready=1 on the 4th edge with in_memory=32'h12345678 → out=32'h12345678, out_busy high for exactly 4 cycles, one out_done pulse.
- Signed byte read: in_size=00, in_addr_lo=2, in_signed=1, in_memory=32'h00F00000 → out=32'hFFFFFFF0. The same read with in_signed=0 → out=32'h000000F0.
- Halfword read with odd offset: in_size=01, in_addr_lo=3, in_signed=1, in_memory=32'h80010000 → out=32'hFFFF8001.
- Timeout: TIMEOUT=4, request with in_mem_ready held 0 → out_timeout pulses after edge 4, out keeps its old value, and a later in_mem_ready is ignored.
- Conflicts: in_read_req and in_write together → the read starts and out is not loaded from in_bus. in_write during WAIT → ignored. in_clr=0 during WAIT → no done pulse and out=0.
